// File: rtl/ilas_pkg.sv
// Shared constants and state encoding for the JESD204B ILAS generator.
package ilas_pkg;

    localparam logic [7:0] K_R = 8'h1C;
    localparam logic [7:0] K_A = 8'h7C;
    localparam logic [7:0] K_Q = 8'h9C;

    localparam int CFG_OFFSET = 2;

    typedef enum logic [1:0] {
        IDLE,
        PREFETCH,
        RUN,
        FIN
    } state_t;

endpackage

// File: rtl/ilas_seq_gen.sv
// Produces the ILAS octet stream for one lane, fetching the link-config octets
// from an external registered ROM and splicing them into multiframe 1.
module ilas_seq_gen
    import ilas_pkg::*;
#(
    parameter int F              = 2,
    parameter int K              = 16,
    parameter int NUM_MF         = 4,
    parameter int CFG_LEN        = 14,
    parameter int CFG_BASE       = 0,
    parameter int ROM_ADDR_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_start,
    output logic [ROM_ADDR_WIDTH-1:0] o_rom_addr,
    output logic                      o_rom_rd_en,
    input  logic [7:0]                i_rom_data,
    output logic [7:0]                o_data,
    output logic                      o_is_k,
    output logic                      o_valid,
    output logic                      o_busy,
    output logic                      o_done
);

    localparam int FK  = F * K;
    localparam int P_W = $clog2(FK);
    localparam int M_W = (NUM_MF > 1) ? $clog2(NUM_MF) : 1;

    localparam logic [P_W-1:0]            P_LAST     = P_W'(FK - 1);
    localparam logic [M_W-1:0]            M_LAST     = M_W'(NUM_MF - 1);
    localparam logic [M_W-1:0]            M_CFG      = M_W'(1);
    localparam logic [P_W-1:0]            P_Q        = P_W'(CFG_OFFSET - 1);
    localparam logic [P_W-1:0]            CFG_FIRST  = P_W'(CFG_OFFSET);
    localparam logic [P_W-1:0]            CFG_END    = P_W'(CFG_OFFSET + CFG_LEN);
    localparam logic [P_W-1:0]            FETCH_END  = P_W'(CFG_LEN);
    localparam logic [ROM_ADDR_WIDTH-1:0] BASE_ADDR  = ROM_ADDR_WIDTH'(CFG_BASE);

    if (FK < 17 || FK > 256) begin : g_bad_frame_len
        $error("ilas_seq_gen: F*K must lie in 17..256");
    end

    state_t                    state_q, state_d;
    logic [P_W-1:0]            p_q, p_d;
    logic [M_W-1:0]            m_q, m_d;
    logic [7:0]                data_q, data_d;
    logic                      is_k_q, is_k_d;
    logic                      valid_q, valid_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      rd_en_q, rd_en_d;
    logic [ROM_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                      cfg_mf;

    assign cfg_mf = (m_q == M_CFG);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            p_q     <= '0;
            m_q     <= '0;
            data_q  <= '0;
            is_k_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_en_q <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            m_q     <= m_d;
            data_q  <= data_d;
            is_k_q  <= is_k_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_en_q <= rd_en_d;
            addr_q  <= addr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        m_d     = m_q;
        data_d  = '0;
        is_k_d  = 1'b0;
        valid_d = 1'b0;
        done_d  = 1'b0;
        busy_d  = (state_q != IDLE);
        rd_en_d = 1'b0;
        addr_d  = addr_q;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    state_d = PREFETCH;
                    p_d     = '0;
                    m_d     = '0;
                end
            end
            PREFETCH: begin
                state_d = RUN;
            end
            RUN: begin
                valid_d = 1'b1;
                if (p_q == '0) begin
                    data_d = K_R;
                    is_k_d = 1'b1;
                end else if (p_q == P_LAST) begin
                    data_d = K_A;
                    is_k_d = 1'b1;
                end else if (cfg_mf && p_q == P_Q) begin
                    data_d = K_Q;
                    is_k_d = 1'b1;
                end else if (cfg_mf && p_q >= CFG_FIRST && p_q < CFG_END) begin
                    data_d = i_rom_data;
                end else begin
                    data_d = 8'(p_q);
                end

                // Fetch runs CFG_OFFSET octets ahead so the ROM word lands exactly on its slot.
                if (cfg_mf && p_q < FETCH_END) begin
                    rd_en_d = 1'b1;
                    addr_d  = BASE_ADDR + ROM_ADDR_WIDTH'(p_q);
                end

                if (p_q == P_LAST) begin
                    p_d = '0;
                    if (m_q == M_LAST) begin
                        state_d = FIN;
                    end else begin
                        m_d = m_q + M_W'(1);
                    end
                end else begin
                    p_d = p_q + P_W'(1);
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_rom_addr  = addr_q;
    assign o_rom_rd_en = rd_en_q;
    assign o_data      = data_q;
    assign o_is_k      = is_k_q;
    assign o_valid     = valid_q;
    assign o_busy      = busy_q;
    assign o_done      = done_q;

endmodule

// File: tb/tb_ilas_seq_gen.sv
// Scoreboard bench for ilas_seq_gen: a default instance and a minimum-length
// (F=1, K=17, CFG_BASE=0x20) instance, each with its own registered ROM model.
module tb_ilas_seq_gen;

    typedef struct {
        logic [7:0] data;
        logic       k;
        bit         cfg;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       dut_start [2];
    logic [7:0] rom_addr  [2];
    logic       rom_rd_en [2];
    logic [7:0] rom_q     [2];
    logic [7:0] dut_data  [2];
    logic       dut_is_k  [2];
    logic       dut_valid [2];
    logic       dut_busy  [2];
    logic       dut_done  [2];

    logic [7:0] rom [2][256];

    exp_t exp_q    [2][$];
    int   done_q   [2][$];
    int   rd_addr_q[2][$];
    int   rd_cyc_q [2][$];

    int cyc = 0;
    int compared = 0;
    int mismatched = 0;

    ilas_seq_gen u_dut0 (
        .clk(clk), .rst(rst), .i_start(dut_start[0]),
        .o_rom_addr(rom_addr[0]), .o_rom_rd_en(rom_rd_en[0]), .i_rom_data(rom_q[0]),
        .o_data(dut_data[0]), .o_is_k(dut_is_k[0]), .o_valid(dut_valid[0]),
        .o_busy(dut_busy[0]), .o_done(dut_done[0])
    );

    ilas_seq_gen #(.F(1), .K(17), .CFG_BASE(32)) u_dut1 (
        .clk(clk), .rst(rst), .i_start(dut_start[1]),
        .o_rom_addr(rom_addr[1]), .o_rom_rd_en(rom_rd_en[1]), .i_rom_data(rom_q[1]),
        .o_data(dut_data[1]), .o_is_k(dut_is_k[1]), .o_valid(dut_valid[1]),
        .o_busy(dut_busy[1]), .o_done(dut_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rom_rd_en[i]) rom_q[i] <= rom[i][rom_addr[i]];
        end
    end

    function automatic int fk_of(input int i);
        return (i == 0) ? 32 : 17;
    endfunction

    function automatic int base_of(input int i);
        return (i == 0) ? 0 : 32;
    endfunction

    // Octet n of a sequence: m = n / FK, p = n % FK, content from the lane rules.
    function automatic exp_t model(input int fk, input int m, input int p,
                                   input logic [7:0] cfg_val, input int first_cyc);
        exp_t r;
        r.cfg = 1'b0;
        r.k   = 1'b0;
        r.cyc = first_cyc;
        if (p == 0) begin
            r.data = 8'h1C; r.k = 1'b1;
        end else if (p == fk - 1) begin
            r.data = 8'h7C; r.k = 1'b1;
        end else if (m == 1 && p == 1) begin
            r.data = 8'h9C; r.k = 1'b1;
        end else if (m == 1 && p >= 2 && p < 16) begin
            r.data = cfg_val; r.cfg = 1'b1;
        end else begin
            r.data = 8'(p);
        end
        return r;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        compared++;
        if (actual != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Called just after a negedge: the start pulse is sampled at the next posedge (edge s).
    task automatic applyStimulus(input int i, output int s);
        int fk;
        int base;
        exp_t e;
        fk   = fk_of(i);
        base = base_of(i);
        s    = cyc + 1;
        for (int n = 0; n < 4 * fk; n++) begin
            e = model(fk, n / fk, n % fk, rom[i][(base + (n % fk) - 2) & 255], (n == 0) ? s + 2 : 0);
            exp_q[i].push_back(e);
        end
        for (int j = 0; j < 14; j++) rd_addr_q[i].push_back((base + j) & 255);
        done_q[i].push_back(s + 2 + 4 * fk);
        dut_start[i] = 1'b1;
        @(negedge clk);
        dut_start[i] = 1'b0;
    endtask

    task automatic pulseAt(input int i, input int edge_cyc);
        while (cyc < edge_cyc - 1) @(negedge clk);
        dut_start[i] = 1'b1;
        @(negedge clk);
        dut_start[i] = 1'b0;
    endtask

    task automatic waitIdle(input int i);
        bit idle;
        idle = 1'b0;
        for (int n = 0; n < 400 && !idle; n++) begin
            if (exp_q[i].size() == 0 && done_q[i].size() == 0 && !dut_busy[i]) idle = 1'b1;
            else @(negedge clk);
        end
        if (!idle) checkOutput("idle_timeout", 0, 1);
    endtask

    task automatic waitDone(input int i, output int dcyc);
        dcyc = -1;
        for (int n = 0; n < 400 && dcyc < 0; n++) begin
            @(negedge clk);
            if (dut_done[i]) dcyc = cyc;
        end
        if (dcyc < 0) checkOutput("done_timeout", 0, 1);
    endtask

    task automatic checkResetState(input int i);
        checkOutput("rst_data",  int'(dut_data[i]),  0);
        checkOutput("rst_is_k",  int'(dut_is_k[i]),  0);
        checkOutput("rst_valid", int'(dut_valid[i]), 0);
        checkOutput("rst_busy",  int'(dut_busy[i]),  0);
        checkOutput("rst_done",  int'(dut_done[i]),  0);
        checkOutput("rst_rd_en", int'(rom_rd_en[i]), 0);
        checkOutput("rst_addr",  int'(rom_addr[i]),  0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                if (dut_valid[i]) begin
                    if (exp_q[i].size() == 0) begin
                        checkOutput("spurious_valid", int'(dut_valid[i]), 0);
                    end else begin
                        e = exp_q[i].pop_front();
                        checkOutput("octet_data", int'(dut_data[i]), int'(e.data));
                        checkOutput("octet_is_k", int'(dut_is_k[i]), int'(e.k));
                        if (e.cyc != 0) checkOutput("first_octet_cycle", cyc, e.cyc);
                        if (e.cfg) begin
                            if (rd_cyc_q[i].size() == 0) checkOutput("rom_fetch_missing", 0, 1);
                            else checkOutput("rom_fetch_lead", cyc - rd_cyc_q[i].pop_front(), 2);
                        end
                    end
                end else begin
                    checkOutput("idle_octet_zero", int'({dut_is_k[i], dut_data[i]}), 0);
                end
                if (rom_rd_en[i]) begin
                    if (rd_addr_q[i].size() == 0) checkOutput("spurious_rd_en", int'(rom_rd_en[i]), 0);
                    else checkOutput("rom_addr", int'(rom_addr[i]), rd_addr_q[i].pop_front());
                    rd_cyc_q[i].push_back(cyc);
                end
                if (dut_done[i]) begin
                    if (done_q[i].size() == 0) checkOutput("spurious_done", int'(dut_done[i]), 0);
                    else checkOutput("done_cycle", cyc, done_q[i].pop_front());
                    checkOutput("busy_at_done", int'(dut_busy[i]), 1);
                end
            end
        end
    end

    initial begin
        int s;
        int d;
        int first;
        int i;

        rst = 1'b1;
        dut_start[0] = 1'b0;
        dut_start[1] = 1'b0;
        for (int a = 0; a < 256; a++) begin
            rom[0][a] = 8'($urandom);
            rom[1][a] = 8'($urandom);
        end
        for (int j = 0; j < 14; j++) rom[0][j] = 8'(8'hA0 + j);

        repeat (3) @(negedge clk);
        checkResetState(0);
        checkResetState(1);
        rst = 1'b0;
        @(negedge clk);
        checkResetState(0);

        $display("[TB] single sequence, default geometry");
        applyStimulus(0, s);
        waitIdle(0);

        $display("[TB] start re-pulsed in PREFETCH, mid-RUN and FIN");
        @(negedge clk);
        applyStimulus(0, s);
        pulseAt(0, s + 1);
        pulseAt(0, s + 2 + $urandom_range(10, 100));
        pulseAt(0, s + 130);
        waitIdle(0);

        $display("[TB] reset at MF2 p=10");
        @(negedge clk);
        applyStimulus(0, s);
        while (cyc < s + 2 + 74) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkResetState(0);
        exp_q[0].delete();
        done_q[0].delete();
        rd_addr_q[0].delete();
        rd_cyc_q[0].delete();
        rst = 1'b0;
        @(negedge clk);
        applyStimulus(0, s);
        waitIdle(0);

        $display("[TB] minimum length F=1 K=17 CFG_BASE=0x20");
        @(negedge clk);
        applyStimulus(1, s);
        waitIdle(1);

        $display("[TB] back-to-back sequences");
        @(negedge clk);
        applyStimulus(0, s);
        waitDone(0, d);
        applyStimulus(0, s);
        first = -1;
        for (int n = 0; n < 10 && first < 0; n++) begin
            if (dut_valid[0]) first = cyc;
            else @(negedge clk);
        end
        checkOutput("b2b_gap", first - d - 1, 2);
        waitIdle(0);

        $display("[TB] randomized sequences");
        for (int r = 0; r < 4; r++) begin
            i = int'($urandom_range(0, 1));
            for (int j = 0; j < 14; j++) rom[i][(base_of(i) + j) & 255] = 8'($urandom);
            repeat ($urandom_range(1, 5)) @(negedge clk);
            applyStimulus(i, s);
            pulseAt(i, s + int'($urandom_range(1, 60)));
            waitIdle(i);
        end

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            checkOutput("leftover_octets", exp_q[k].size(), 0);
            checkOutput("leftover_rd", rd_addr_q[k].size(), 0);
            checkOutput("leftover_done", done_q[k].size(), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
